// File: rtl/lifetime_pkg.sv
// Shared constants and FSM state encoding for the lifetime histogram.
package lifetime_pkg;

    localparam int DEF_NUM_BINS    = 32;
    localparam int DEF_BIN_SHIFT   = 3;
    localparam int DEF_COUNT_WIDTH = 16;
    localparam int MEAS_WIDTH      = 16;

    typedef logic [0:0] hist_state_t;

    localparam hist_state_t ST_RUN   = 1'b0;
    localparam hist_state_t ST_CLEAR = 1'b1;

endpackage

// File: rtl/lifetime_histogram_hist_counter.sv
// Event counter with synchronous clear; saturates at all-ones when
// LIFETIME_HIST_SATURATE_EN is defined, otherwise wraps.
module hist_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc) begin
`ifdef LIFETIME_HIST_SATURATE_EN
            if (count_q != '1) begin
                count_d = count_q + WIDTH'(1);
            end
`else
            count_d = count_q + WIDTH'(1);
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/lifetime_histogram.sv
// Decay-time histogram: bins TDC measurements, sweeps bins to zero on clear/reset.
// Optional macro LIFETIME_HIST_SATURATE_EN makes all counters saturate instead of wrap.
module lifetime_histogram
    import lifetime_pkg::*;
#(
    parameter int NUM_BINS    = DEF_NUM_BINS,
    parameter int BIN_SHIFT   = DEF_BIN_SHIFT,
    parameter int COUNT_WIDTH = DEF_COUNT_WIDTH
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        meas_valid,
    input  logic [MEAS_WIDTH-1:0]       meas_time,
    input  logic                        clear,
    input  logic                        rd_req,
    input  logic [$clog2(NUM_BINS)-1:0] rd_addr,
    output logic                        rd_valid,
    output logic [COUNT_WIDTH-1:0]      rd_data,
    output logic [COUNT_WIDTH-1:0]      total_events,
    output logic [COUNT_WIDTH-1:0]      overflow_events,
    output logic                        busy
);

    localparam int AW = $clog2(NUM_BINS);

    hist_state_t                state_q, state_d;
    logic [AW-1:0]              sweep_idx_q, sweep_idx_d;
    logic                       rd_valid_q, rd_valid_d;
    logic [COUNT_WIDTH-1:0]     rd_data_q, rd_data_d;

    logic                       in_clear;
    logic                       evt_clr;
    logic                       meas_accept;
    logic                       hit_bin;
    logic                       hit_ovf;
    logic [MEAS_WIDTH-1:0]      meas_idx;
    logic [NUM_BINS-1:0]        bin_inc;
    logic [NUM_BINS-1:0]        bin_clr;
    logic [NUM_BINS-1:0][COUNT_WIDTH-1:0] bin_count;

    // A zero time means the TDC timed out; a clear on the same cycle wins over the hit.
    always_comb begin
        in_clear    = (state_q == ST_CLEAR);
        evt_clr     = in_clear && (sweep_idx_q == '0);
        meas_idx    = meas_time >> BIN_SHIFT;
        meas_accept = !in_clear && meas_valid && !clear && (meas_time != '0);
        hit_bin     = meas_accept && (meas_idx <  MEAS_WIDTH'(NUM_BINS));
        hit_ovf     = meas_accept && (meas_idx >= MEAS_WIDTH'(NUM_BINS));
    end

    always_comb begin
        bin_inc = '0;
        bin_clr = '0;
        for (int i = 0; i < NUM_BINS; i++) begin
            bin_inc[i] = hit_bin && (meas_idx[AW-1:0] == AW'(i));
            bin_clr[i] = in_clear && (sweep_idx_q == AW'(i));
        end
    end

    always_comb begin
        state_d     = state_q;
        sweep_idx_d = sweep_idx_q;
        if (in_clear) begin
            if (sweep_idx_q == AW'(NUM_BINS - 1)) begin
                state_d     = ST_RUN;
                sweep_idx_d = '0;
            end else begin
                sweep_idx_d = sweep_idx_q + AW'(1);
            end
        end else if (clear) begin
            state_d     = ST_CLEAR;
            sweep_idx_d = '0;
        end
    end

    // Reads during the sweep return zero since bins may hold stale counts.
    always_comb begin
        rd_valid_d = rd_req;
        rd_data_d  = rd_data_q;
        if (rd_req) begin
            rd_data_d = in_clear ? '0 : bin_count[rd_addr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_CLEAR;
            sweep_idx_q <= '0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            sweep_idx_q <= sweep_idx_d;
            rd_valid_q  <= rd_valid_d;
            rd_data_q   <= rd_data_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BINS; gi++) begin : g_bin
            hist_counter #(.WIDTH(COUNT_WIDTH)) u_bin (
                .clk   (clk),
                .rst_n (rst_n),
                .clr   (bin_clr[gi]),
                .inc   (bin_inc[gi]),
                .count (bin_count[gi])
            );
        end
    endgenerate

    hist_counter #(.WIDTH(COUNT_WIDTH)) u_total (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (evt_clr),
        .inc   (hit_bin),
        .count (total_events)
    );

    hist_counter #(.WIDTH(COUNT_WIDTH)) u_overflow (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (evt_clr),
        .inc   (hit_ovf),
        .count (overflow_events)
    );

    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;
    assign busy     = in_clear;

endmodule
